bcd_serial_add_ctrl: RTL and testbench

Digit-serial sequencer for an M-digit packed-BCD addition.
- Latches two M-digit operands and a carry-in.
- Drives one external single-digit BCD adder (combinational, 4-bit sum/carry) for one digit per clock, LSD first.
- Chains the carry between digits and assembles the M-digit result.
- Trades M+1 cycles of latency for one digit adder instead of M; exposes a start/ready/done handshake to the surrounding datapath.

---
 rtl/bcd_serial_add_ctrl.sv | 136 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: feeds one external single-digit
// BCD adder per clock (LSD first), chains the carry and assembles the result.
`timescale 1ns/1ps
module bcd_serial_add_ctrl #(
  parameter int M = 3,
  parameter int N = 4 * M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [3:0]   dig_x,
  output logic [3:0]   dig_y,
  output logic         dig_cin,
  input  logic [3:0]   dig_sum,
  input  logic         dig_cout,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  opx_q, opx_d, opy_q, opy_d;
  logic [N-1:0]  psum_q, psum_d;
  logic          carry_q, carry_d;
  logic          err_pend_q, err_pend_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;

  logic [N-1:0]  dig_sum_top;
  logic [N-1:0]  psum_shift;
  logic          bad_nibble;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    bad_nibble  = 1'b0;
    for (int i = 0; i < M; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad_nibble = 1'b1;
    end
    dig_sum_top          = '0;
    dig_sum_top[N-1 -: 4] = dig_sum;
    psum_shift  = (psum_q >> 4) | dig_sum_top;

    state_d    = state_q;
    cnt_d      = cnt_q;
    opx_d      = opx_q;
    opy_d      = opy_q;
    psum_d     = psum_q;
    carry_d    = carry_q;
    err_pend_d = err_pend_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    err_d      = err_q;

    case (state_q)
      S_RUN: begin
        opx_d   = opx_q >> 4;
        opy_d   = opy_q >> 4;
        psum_d  = psum_shift;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          sum_d   = psum_shift;
          cout_d  = dig_cout;
          err_d   = err_pend_q;
        end
      end
      default: begin
        // IDLE and DONE accept a new request identically.
        if (start) begin
          state_d    = S_RUN;
          opx_d      = x;
          opy_d      = y;
          carry_d    = cin;
          cnt_d      = '0;
          psum_d     = '0;
          err_pend_d = bad_nibble;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opx_q      <= '0;
      opy_q      <= '0;
      psum_q     <= '0;
      carry_q    <= 1'b0;
      err_pend_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opx_q      <= opx_d;
      opy_q      <= opy_d;
      psum_q     <= psum_d;
      carry_q    <= carry_d;
      err_pend_q <= err_pend_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
    end
  end

  // Status and digit outputs decode straight from flops; digits are forced to 0 outside RUN.
  assign busy    = (state_q == S_RUN);
  assign ready   = (state_q != S_RUN);
  assign done    = (state_q == S_DONE);
  assign dig_x   = busy ? opx_q[3:0] : 4'd0;
  assign dig_y   = busy ? opy_q[3:0] : 4'd0;
  assign dig_cin = busy & carry_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench: directed cases plus random ops against a decimal-arithmetic model.
`timescale 1ns/1ps
module tb_bcd_serial_add_ctrl;

  localparam int M = 3;
  localparam int N = 4 * M;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [N-1:0] x, y;
  logic         cin;
  logic [3:0]   dig_x, dig_y;
  logic         dig_cin;
  logic [3:0]   dig_sum;
  logic         dig_cout;
  logic         busy, done;
  logic [N-1:0] sum;
  logic         cout, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] prev_sum;
  logic         prev_cout;
  bit           prev_valid;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .x(x), .y(y), .cin(cin),
    .dig_x(dig_x), .dig_y(dig_y), .dig_cin(dig_cin),
    .dig_sum(dig_sum), .dig_cout(dig_cout),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  // External single-digit BCD adder.
  always_comb begin
    int t;
    t = int'(dig_x) + int'(dig_y) + int'(dig_cin);
    dig_cout = (t > 9);
    dig_sum  = (t > 9) ? 4'(t - 10) : 4'(t);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimal value of the low k digits of a packed-BCD word.
  function automatic longint bcd_val(input logic [N-1:0] v, input int k);
    longint r = 0;
    longint w = 1;
    for (int i = 0; i < k; i++) begin
      r += longint'(v[4*i +: 4]) * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic longint pow10(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r *= 10;
    return r;
  endfunction

  function automatic logic exp_carry(input logic [N-1:0] a, b, input logic ci, input int k);
    return (bcd_val(a, k) + bcd_val(b, k) + longint'(ci)) >= pow10(k);
  endfunction

  task automatic ref_add(input logic [N-1:0] a, b, input logic ci,
                         output logic [N-1:0] es, output logic ec, output logic ee);
    longint t;
    ee = 1'b0;
    for (int i = 0; i < M; i++)
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) ee = 1'b1;
    t  = bcd_val(a, M) + bcd_val(b, M) + longint'(ci);
    ec = (t >= pow10(M));
    t  = t % pow10(M);
    es = '0;
    for (int i = 0; i < M; i++) begin
      es[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endtask

  // Issue one op at the current negedge and check every cycle through DONE.
  // hold=1 leaves start high at the DONE cycle so the next call chains back-to-back.
  task automatic run_op(input logic [N-1:0] a, b, input logic ci, input bit hold);
    logic [N-1:0] es;
    logic ec, ee;
    ref_add(a, b, ci, es, ec, ee);
    check("ready_at_issue", 32'(ready), 32'd1);
    x = a; y = b; cin = ci; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < M; k++) begin
      @(negedge clk);
      check("run_busy", 32'(busy), 32'd1);
      check("run_ready", 32'(ready), 32'd0);
      check("run_done", 32'(done), 32'd0);
      check("dig_x", 32'(dig_x), 32'(a[4*k +: 4]));
      check("dig_y", 32'(dig_y), 32'(b[4*k +: 4]));
      if (!ee) check("dig_cin", 32'(dig_cin), 32'(exp_carry(a, b, ci, k)));
      if (prev_valid) begin
        check("sum_held", 32'(sum), 32'(prev_sum));
        check("cout_held", 32'(cout), 32'(prev_cout));
      end
      x = N'($urandom); y = N'($urandom); cin = 1'($urandom);
      if (!hold) start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_ready", 32'(ready), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("idle_dig_x", 32'(dig_x), 32'd0);
    check("err", 32'(err), 32'(ee));
    if (!ee) begin
      check("sum", 32'(sum), 32'(es));
      check("cout", 32'(cout), 32'(ec));
    end
    prev_valid = !ee;
    prev_sum   = sum;
    prev_cout  = cout;
    if (prev_valid) begin
      prev_sum  = es;
      prev_cout = ec;
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_dig_cin", 32'(dig_cin), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    prev_valid = 1'b1; prev_sum = '0; prev_cout = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dig_x", 32'(dig_x), 32'd0);
    rst = 1'b0;
    idle_cycle();

    run_op(12'h123, 12'h456, 1'b0, 1'b0);
    idle_cycle();
    run_op(12'h999, 12'h001, 1'b0, 1'b0);
    run_op(12'h500, 12'h499, 1'b1, 1'b0);
    run_op(12'h1A3, 12'h000, 1'b0, 1'b0);
    check("err_sticky", 32'(err), 32'd1);
    idle_cycle();
    run_op(12'h111, 12'h222, 1'b0, 1'b0);
    run_op(12'h250, 12'h250, 1'b0, 1'b1);
    run_op(12'h001, 12'h002, 1'b0, 1'b0);
    idle_cycle();

    // Abort in the second RUN cycle.
    run_op(12'h123, 12'h456, 1'b0, 1'b0);
    x = 12'h999; y = 12'h999; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_valid = 1'b1; prev_sum = '0; prev_cout = 1'b0;
    repeat (3) idle_cycle();
    run_op(12'h999, 12'h999, 1'b0, 1'b0);
    idle_cycle();

    for (int i = 0; i < 24; i++) begin
      bit hold;
      for (int d = 0; d < M; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) begin
        int d = $urandom_range(0, M - 1);
        if ($urandom_range(0, 1) == 1) ra[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*d +: 4] = 4'($urandom_range(10, 15));
      end
      hold = (i != 23) && ($urandom_range(0, 1) == 1);
      run_op(ra, rb, 1'($urandom), hold);
      if (!hold && $urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
